// File: rtl/m_store_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : m_store_buffer_if
// Purpose  : Store/load/DM-port bundle for m_store_buffer (master = pipeline side).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DM_sb
`define DM_sb 2'b00
`endif
`ifndef DM_sh
`define DM_sh 2'b01
`endif
`ifndef DM_sw
`define DM_sw 2'b10
`endif

interface m_store_buffer_if #(
    parameter int PTR_W = 2
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [1:0]       st_type;
    logic [31:0]      st_pc;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_stall;
    logic             ld_fwd_valid;
    logic [31:0]      ld_fwd_data;
    logic             dm_ready;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wd;
    logic [1:0]       dm_type;
    logic [31:0]      dm_pc;
    logic [PTR_W:0]   count;
    logic             empty;

    modport master (
        output st_valid, st_addr, st_data, st_type, st_pc, ld_valid, ld_addr, dm_ready,
        input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
               dm_we, dm_addr, dm_wd, dm_type, dm_pc, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_type, st_pc, ld_valid, ld_addr, dm_ready,
        output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
               dm_we, dm_addr, dm_wd, dm_type, dm_pc, count, empty
    );
endinterface

`default_nettype wire

// File: rtl/m_store_buffer.sv
//------------------------------------------------------------------------------
// Module   : m_store_buffer
// Purpose  : FIFO store buffer between M-stage and DM write port with load-hazard
//            detection; optional store-to-load forwarding under SB_LOAD_FWD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    m_store_buffer_if.slave  sb
);

    localparam logic [1:0]     c_TYPE_SW = `DM_sw;
    localparam logic [PTR_W:0] c_PTR_ONE = 1;

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [1:0]       r_type [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_head_idx;
    logic [PTR_W-1:0] w_tail_idx;
    logic [PTR_W-1:0] w_scan_idx;
    logic             w_hit;
    logic [1:0]       w_hit_type;
    logic [31:0]      w_hit_data;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign w_full     = (r_head[PTR_W] != r_tail[PTR_W]) && (w_head_idx == w_tail_idx);
    assign w_empty    = (r_head == r_tail);
    // Push uses the pre-pop full flag: a same-cycle drain never frees a slot.
    assign w_push     = sb.st_valid && !w_full;
    assign w_pop      = !w_empty && sb.dm_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_tail              <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_tail_idx] <= sb.st_addr;
            r_data[w_tail_idx] <= sb.st_data;
            r_type[w_tail_idx] <= sb.st_type;
            r_pc[w_tail_idx]   <= sb.st_pc;
        end
    end

    assign sb.st_ready = !w_full;
    assign sb.dm_we    = w_pop;
    assign sb.dm_addr  = w_empty ? 32'd0 : r_addr[w_head_idx];
    assign sb.dm_wd    = w_empty ? 32'd0 : r_data[w_head_idx];
    assign sb.dm_type  = w_empty ? 2'd0  : r_type[w_head_idx];
    assign sb.dm_pc    = w_empty ? 32'd0 : r_pc[w_head_idx];
    assign sb.count    = r_tail - r_head;
    assign sb.empty    = w_empty;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_type = '0;
        w_hit_data = '0;
        w_scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = w_head_idx + PTR_W'(k);
            if (r_valid[w_scan_idx] && (r_addr[w_scan_idx][31:2] == sb.ld_addr[31:2])) begin
                w_hit      = 1'b1;
                w_hit_type = r_type[w_scan_idx];
                w_hit_data = r_data[w_scan_idx];
            end
        end
    end

`ifdef SB_LOAD_FWD_EN
    assign sb.ld_fwd_valid = sb.ld_valid && w_hit && (w_hit_type == c_TYPE_SW);
    assign sb.ld_fwd_data  = sb.ld_fwd_valid ? w_hit_data : 32'd0;
    assign sb.ld_stall     = sb.ld_valid && w_hit && (w_hit_type != c_TYPE_SW);
`else
    logic w_unused_fwd;
    assign w_unused_fwd    = ^{w_hit_type, w_hit_data, c_TYPE_SW};
    assign sb.ld_fwd_valid = 1'b0;
    assign sb.ld_fwd_data  = 32'd0;
    assign sb.ld_stall     = sb.ld_valid && w_hit;
`endif

endmodule

`default_nettype wire

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- FIFO write buffer between the M-stage store path and the data memory write port.
- Accepts stores from the pipeline and drains them to DM one per cycle whenever DM signals ready.
- Flags loads that hit a pending store word, so hazard control can stall M.
- Lets the DM port be a future bus/cache with backpressure without stalling every store.

Parameters:
- DEPTH, 4: number of entries; power of 2, minimum 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  M-stage store request this cycle
- st_addr  in  32  byte address of store
- st_data  in  32  store data, unshifted, in register format
- st_type  in  2  store type: `DM_sw / `DM_sh / `DM_sb from the shared define header
- st_pc  in  32  PC of the store instruction
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  M-stage load request this cycle
- ld_addr  in  32  byte address of load
- ld_stall  out  1  load must wait: matching word still pending
- ld_fwd_valid  out  1  forwarded load data valid (optional feature)
- ld_fwd_data  out  32  forwarded word (optional feature)
- dm_ready  in  1  DM accepts a write this cycle
- dm_we  out  1  write strobe to DM
- dm_addr  out  32  head-entry address
- dm_wd  out  32  head-entry data
- dm_type  out  2  head-entry store type
- dm_pc  out  32  head-entry PC
- count  out  PTR_W+1  number of valid entries
- empty  out  1  count == 0

Behaviour:
- Storage:
  - Circular FIFO of {addr, data, type, pc} plus a valid bit per entry.
  - head and tail pointers are PTR_W+1 bits wide; the extra bit is the wrap flag.
  - full when pointers differ only in the wrap bit; empty when they are equal.
- Push:
  - st_ready = !full, combinational.
  - At posedge, if st_valid && st_ready: write entry at tail, set its valid bit, tail+1.
  - st_valid while full: the store is not accepted. The upstream stage must stall and hold the request.
  - A pop in the same cycle does not free a slot for the push; there is no same-cycle pass-through.
- Pop:
  - dm_we = !empty && dm_ready, combinational.
  - dm_addr / dm_wd / dm_type / dm_pc always show the head entry. They are don't-care when empty; drive 0.
  - At posedge, if dm_we: clear head valid bit, head+1.
- Latency:
  - A store pushed in cycle N appears at the DM port at earliest in cycle N+1.
  - The buffer never drops or reorders entries.
- Simultaneous push and pop: both occur; count is unchanged.
  - When full, push is blocked (st_ready=0) even if a pop occurs that cycle.
- Wrap-around: pointers wrap modulo 2*DEPTH; entry index is ptr[PTR_W-1:0].
- Load hazard:
  - ld_stall = ld_valid && any valid entry has addr[31:2] == ld_addr[31:2]. This includes the head entry being drained this cycle.
  - No stall on a byte-lane mismatch inside the same word; the comparison is word-granular.
- Reset:
  - head = tail = 0, all valid bits 0, count 0.
  - empty=1, st_ready=1, dm_we=0, ld_stall=0, ld_fwd_valid=0, ld_fwd_data=0.
  - Entries pending at reset are discarded and never written to DM.
- count = tail - head. Its width holds the value DEPTH.

Optional Feature:
- Macro SB_LOAD_FWD_EN.
- Defined:
  - On a word match, locate the youngest matching valid entry (closest to tail).
  - If its st_type is `DM_sw: ld_fwd_valid=1, ld_fwd_data = its data, ld_stall=0.
  - If the youngest match is sh/sb: ld_stall=1, ld_fwd_valid=0.
  - No match: both 0.
  - Forward data is the full word. Load byte/half extraction is done downstream by the DM read mux.
- Undefined: ld_fwd_valid and ld_fwd_data are tied to 0, and every word match stalls.

Test Plan:
- Reset, then push sw addr=0x10 data=0x12345678 pc=0x3000 with dm_ready=1.
  - Next cycle: dm_we=1, dm_addr=0x10, dm_wd=0x12345678, dm_pc=0x3000.
  - Cycle after: empty=1.
- dm_ready=0, push 4 stores to addrs 0x0, 0x4, 0x8, 0xC.
  - count=4, st_ready=0.
  - A 5th st_valid is not accepted.
  - Raise dm_ready: drain order is 0x0, 0x4, 0x8, 0xC, one per cycle.
- Full buffer with simultaneous st_valid and dm_ready=1.
  - Pop occurs, push is refused; count goes 4 -> 3.
  - Next cycle the push is accepted; count = 3.
- Pending sb at addr 0x21, load ld_addr=0x22 -> ld_stall=1.
  - Load ld_addr=0x24 -> ld_stall=0.
  - After the 0x21 entry drains -> ld_stall=0 for 0x22.
- With SB_LOAD_FWD_EN: pending sw 0x40=0xAAAA0000, then sw 0x40=0xBBBB1111; ld_addr=0x40.
  - Response: ld_fwd_valid=1, ld_fwd_data=0xBBBB1111, ld_stall=0.
  - Add a newer sh to 0x42 -> ld_stall=1.
- Push 3 entries with dm_ready=0, then assert reset for 1 cycle.
  - count=0, dm_we=0 afterwards.
  - Following dm_ready=1 produces no DM writes.
- Run 10 push/pop cycles to exercise pointer wrap: data order is preserved across the wrap.
